alarm_time_matcher: RTL
=======================

// Module: alarm_time_matcher
// PURPOSE
// - Upstream feeder of the cuckoo ringer: BCD 24 h time-of-day counter plus alarm setpoint.
// - Produces is_same_time, which drives the ringer's isSameTime input.
// - User buttons (already debounced and one-shot) set the current time and the alarm time.
// - Fully synchronous to clk; time advances on a 1 Hz enable pulse, not a derived clock.
// PARAMETERS
// - ALARM_RST_HOUR  8'h06  BCD alarm hour loaded at reset
// - ALARM_RST_MIN   8'h00  BCD alarm minute loaded at reset
// - SNOOZE_MIN      5      snooze delay in minutes, 1..59 (used only with ALARM_SNOOZE_EN)
// PORTS
// - clk             in   1  system clock
// - rst_n           in   1  synchronous, active-low reset
// - tick_1hz        in   1  one-clk-wide pulse, once per second
// - set_mode        in   2  0=RUN, 1=SET_TIME, 2=SET_ALARM, 3=treated as RUN
// - inc_hour        in   1  one-clk pulse: +1 hour in the selected set mode
// - inc_min         in   1  one-clk pulse: +1 minute in the selected set mode
// - snooze          in   1  one-clk pulse: snooze request (ALARM_SNOOZE_EN only, otherwise ignored)
// - hour_bcd        out  8  current hour, BCD 00..23
// - min_bcd         out  8  current minute, BCD 00..59
// - sec_bcd         out  8  current second, BCD 00..59
// - alarm_hour_bcd  out  8  alarm hour, BCD
// - alarm_min_bcd   out  8  alarm minute, BCD
// - is_same_time    out  1  registered match flag to the ringer
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge):
//   - Time 00:00:00.
//   - Alarm = ALARM_RST_HOUR:ALARM_RST_MIN.
//   - is_same_time=0; snooze target invalid.
// - Every output is a register. No combinational path from any input to any output.
// - RUN mode, tick_1hz=1:
//   - Time increments by 1 s; the new value is visible the cycle after the tick.
//   - Carries: sec 59->00 increments min; min 59->00 increments hour; hour 23->00.
//   - 23:59:59 -> 00:00:00 in one tick.
//   - inc_hour and inc_min are ignored.
// - SET_TIME mode:
//   - tick_1hz is ignored.
//   - inc_min: min +1, 59 wraps to 00 with no hour carry.
//   - inc_hour: hour +1, 23 wraps to 00.
//   - Any inc pulse also clears sec to 00.
//   - inc_hour and inc_min in the same cycle both apply.
// - SET_ALARM mode:
//   - Time keeps running exactly as in RUN.
//   - inc_min and inc_hour adjust the alarm registers with the same wrap rules as SET_TIME.
// - Mode change takes effect on the cycle it is sampled. No state is lost on a mode change.
// - Match:
//   - is_same_time <= (set_mode is RUN) && (hour,min == alarm hour,min).
//   - Latency: 1 cycle after the time/alarm registers change.
//   - Held high for the whole matching minute (sec 00..59), low otherwise.
//   - Forced low while in SET_TIME or SET_ALARM.
//   - The ringer edge-detects this flag, so one rising edge per matching minute.
// - Every BCD digit stays legal: no A..F nibbles ever appear, including across wraps.
// CONFIGURATION
// - ALARM_SNOOZE_EN defined:
//   - snooze=1 in RUN while is_same_time=1 loads the snooze target = current hh:mm + SNOOZE_MIN.
//     The target is computed mod 24 h in BCD and marked valid.
//   - Match condition becomes (alarm match) || (target valid && hh:mm == target).
//   - The target is invalidated when its minute ends, on any SET_ALARM inc, and on reset.
//   - snooze while is_same_time=0 is ignored. A repeat snooze during a snooze match re-arms the target.
// - ALARM_SNOOZE_EN undefined:
//   - No snooze logic and no target registers.
//   - The snooze port exists but is unused; match is the alarm compare only.
// TESTING
// 1. Reset -> outputs 00:00:00, alarm 06:00, is_same_time=0.
// 2. SET_TIME, set 23:59, RUN, 60 ticks -> 00:00:00 after the 60th tick. Verify BCD legal every cycle.
// 3. Alarm 00:01, time 00:00:59, one tick -> is_same_time=1 one clk later.
//    It stays 1 through 00:01:59 and drops to 0 at 00:02:00.
// 4. During a match, set_mode=2 -> is_same_time=0 next cycle.
//    inc_hour+inc_min in the same cycle -> alarm 01:02.
// 5. SET_TIME: inc_min at min 59 -> 00 with hour unchanged, sec cleared. tick_1hz ignored in this mode.
// 6. ALARM_SNOOZE_EN, alarm 23:58, snooze at 23:58:10 -> new match at 00:03 (wraps past midnight).
//    Without the macro, no match at 00:03.

Source files
------------

// File: rtl/alarm_time_matcher_if.sv
// rtl/alarm_time_matcher_if.sv - control and status bundle between the clock UI and the alarm time matcher
interface alarm_time_matcher_if;
    logic       tick_1hz;
    logic [1:0] set_mode;
    logic       inc_hour;
    logic       inc_min;
    logic       snooze;
    logic [7:0] hour_bcd;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic [7:0] alarm_hour_bcd;
    logic [7:0] alarm_min_bcd;
    logic       is_same_time;

    modport master (
        output tick_1hz, set_mode, inc_hour, inc_min, snooze,
        input  hour_bcd, min_bcd, sec_bcd, alarm_hour_bcd, alarm_min_bcd, is_same_time
    );

    modport slave (
        input  tick_1hz, set_mode, inc_hour, inc_min, snooze,
        output hour_bcd, min_bcd, sec_bcd, alarm_hour_bcd, alarm_min_bcd, is_same_time
    );
endinterface

// File: rtl/alarm_time_matcher.sv
// rtl/alarm_time_matcher.sv - BCD 24 h clock with alarm setpoint and registered match flag; optional snooze via ALARM_SNOOZE_EN
module alarm_time_matcher #(
    parameter logic [7:0] ALARM_RST_HOUR = 8'h06,
    parameter logic [7:0] ALARM_RST_MIN  = 8'h00,
    parameter int         SNOOZE_MIN     = 5
) (
    input logic                 clk,
    input logic                 rst_n,
    alarm_time_matcher_if.slave bus
);
    typedef enum logic [1:0] {
        MODE_RUN       = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2,
        MODE_RUN_ALT   = 2'd3
    } modeT;

    logic [7:0] hourBcd, minBcd, secBcd, alarmHour, alarmMin;
    logic       isSameTime;
    modeT       mode;
    logic       runMode, setTime, setAlarm, anyInc, alarmEq, matchNow;

    // Wraps straight to 00 at maxV so no A..F nibble is ever produced.
    function automatic logic [7:0] incBcd(input logic [7:0] v, input logic [7:0] maxV);
        if (v == maxV)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return v + 8'd1;
    endfunction

    assign mode = modeT'(bus.set_mode);

    always_comb begin
        runMode  = (mode == MODE_RUN) || (mode == MODE_RUN_ALT);
        setTime  = (mode == MODE_SET_TIME);
        setAlarm = (mode == MODE_SET_ALARM);
        anyInc   = bus.inc_hour || bus.inc_min;
        alarmEq  = (hourBcd == alarmHour) && (minBcd == alarmMin);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hourBcd    <= 8'h00;
            minBcd     <= 8'h00;
            secBcd     <= 8'h00;
            alarmHour  <= ALARM_RST_HOUR;
            alarmMin   <= ALARM_RST_MIN;
            isSameTime <= 1'b0;
        end else begin
            if (setTime) begin
                if (bus.inc_hour) hourBcd <= incBcd(hourBcd, 8'h23);
                if (bus.inc_min)  minBcd  <= incBcd(minBcd, 8'h59);
                if (anyInc)       secBcd  <= 8'h00;
            end else if (bus.tick_1hz) begin
                secBcd <= incBcd(secBcd, 8'h59);
                if (secBcd == 8'h59) begin
                    minBcd <= incBcd(minBcd, 8'h59);
                    if (minBcd == 8'h59) hourBcd <= incBcd(hourBcd, 8'h23);
                end
            end
            if (setAlarm) begin
                if (bus.inc_hour) alarmHour <= incBcd(alarmHour, 8'h23);
                if (bus.inc_min)  alarmMin  <= incBcd(alarmMin, 8'h59);
            end
            isSameTime <= runMode && matchNow;
        end
    end

`ifdef ALARM_SNOOZE_EN
    localparam logic [7:0] SNOOZE_BIN = 8'(SNOOZE_MIN);

    logic [7:0] targetHour, targetMin, nextTargetHour, nextTargetMin, minSum, hourSum;
    logic       targetValid, targetHit, minCarry, snoozeEq;

    function automatic logic [7:0] bcdToBin(input logic [7:0] v);
        return 8'(v[7:4]) * 8'd10 + 8'(v[3:0]);
    endfunction

    function automatic logic [7:0] binToBcd(input logic [7:0] v);
        return ((v / 8'd10) << 4) | (v % 8'd10);
    endfunction

    always_comb begin
        minSum         = bcdToBin(minBcd) + SNOOZE_BIN;
        minCarry       = (minSum >= 8'd60);
        nextTargetMin  = binToBcd(minCarry ? minSum - 8'd60 : minSum);
        hourSum        = bcdToBin(hourBcd) + {7'd0, minCarry};
        nextTargetHour = binToBcd((hourSum >= 8'd24) ? hourSum - 8'd24 : hourSum);
        snoozeEq       = targetValid && (hourBcd == targetHour) && (minBcd == targetMin);
        matchNow       = alarmEq || snoozeEq;
    end

    // targetHit remembers we were inside the target minute, so leaving it retires the target.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            targetHour  <= 8'h00;
            targetMin   <= 8'h00;
            targetValid <= 1'b0;
            targetHit   <= 1'b0;
        end else if (bus.snooze && runMode && isSameTime) begin
            targetHour  <= nextTargetHour;
            targetMin   <= nextTargetMin;
            targetValid <= 1'b1;
            targetHit   <= 1'b0;
        end else if ((setAlarm && anyInc) || (targetHit && !snoozeEq)) begin
            targetValid <= 1'b0;
            targetHit   <= 1'b0;
        end else begin
            targetHit   <= snoozeEq;
        end
    end
`else
    logic unusedSignals;

    assign matchNow      = alarmEq;
    assign unusedSignals = &{1'b0, bus.snooze, SNOOZE_MIN[0]};
`endif

    assign bus.hour_bcd       = hourBcd;
    assign bus.min_bcd        = minBcd;
    assign bus.sec_bcd        = secBcd;
    assign bus.alarm_hour_bcd = alarmHour;
    assign bus.alarm_min_bcd  = alarmMin;
    assign bus.is_same_time   = isSameTime;
endmodule
